// File: rtl/ram_access_sequencer.sv
// Sequencer for the SAP 16x8 RAM and its MAR: arbitrates CPU vs loader requests and
// runs a MAR-load then RAM-access cycle on the shared bus for each granted request.
module ram_access_sequencer #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  input  logic              ldr_lock,
  output logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic              bus_drive,
  output logic [DATA_W-1:0] bus_out,
  output logic              mar_load_n,
  output logic              ram_oe_n,
  output logic              ram_we,
  output logic              busy
);

  if (WR_CYCLES < 1 || WR_CYCLES > 8) begin : g_bad_wr_cycles
    $error("WR_CYCLES must be in 1..8");
  end

  localparam logic [2:0] WrLast = 3'(WR_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMar, StAcc, StDone} state_e;

  state_e              state_q;
  logic                last_ldr_q;  // 1 = loader held the last contested grant
  logic                gnt_ldr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          cnt_q;

  logic                cpu_elig;
  logic                pick_ldr;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  always_comb begin
    cpu_elig  = cpu_req & ~ldr_lock;
    // Loader wins when alone, or on a tie when the CPU had the previous contested grant
    pick_ldr  = ldr_req & (~cpu_elig | ~last_ldr_q);
    sel_we    = pick_ldr ? ldr_we    : cpu_we;
    sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
    sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      last_ldr_q <= 1'b1;
      gnt_ldr_q  <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      mar_load_n <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we     <= 1'b0;
      bus_drive  <= 1'b0;
      bus_out    <= '0;
      rdata      <= '0;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      ldr_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_elig || ldr_req) begin
            gnt_ldr_q <= pick_ldr;
            we_q      <= sel_we;
            wdata_q   <= sel_wdata;
            if (cpu_elig && ldr_req) last_ldr_q <= pick_ldr;
            // MAR phase outputs are loaded straight from the selected request
            mar_load_n <= 1'b0;
            bus_drive  <= 1'b1;
            bus_out    <= DATA_W'(sel_addr);
            state_q    <= StMar;
          end
        end
        StMar: begin
          mar_load_n <= 1'b1;
          state_q    <= StAcc;
          if (we_q) begin
            bus_drive <= 1'b1;
            bus_out   <= wdata_q;
            ram_we    <= 1'b1;
            cnt_q     <= WrLast;
          end else begin
            bus_drive <= 1'b0;
            bus_out   <= '0;
            ram_oe_n  <= 1'b0;
          end
        end
        StAcc: begin
          if (we_q && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else begin
            if (!we_q) rdata <= bus_in;
            ram_we    <= 1'b0;
            ram_oe_n  <= 1'b1;
            bus_drive <= 1'b0;
            bus_out   <= '0;
            cpu_ack   <= ~gnt_ldr_q;
            ldr_ack   <= gnt_ldr_q;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Directed bench for ram_access_sequencer: one instance with WR_CYCLES=1, one with WR_CYCLES=4.
module tb_ram_access_sequencer;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [3:0] cpu_addr, ldr_addr;
  logic [7:0] cpu_wdata, ldr_wdata, bus_in;

  logic       cpu_ack, ldr_ack, bus_drive, mar_load_n, ram_oe_n, ram_we, busy;
  logic [7:0] rdata, bus_out;
  logic       cpu_ack4, ldr_ack4, bus_drive4, mar_load_n4, ram_oe_n4, ram_we4, busy4;
  logic [7:0] rdata4, bus_out4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_access_sequencer #(.ADDR_W(4), .DATA_W(8), .WR_CYCLES(1)) u_dut (
    .clk(clk), .clr_n(clr_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_lock(ldr_lock),
    .rdata(rdata), .bus_in(bus_in), .bus_drive(bus_drive), .bus_out(bus_out),
    .mar_load_n(mar_load_n), .ram_oe_n(ram_oe_n), .ram_we(ram_we), .busy(busy)
  );

  ram_access_sequencer #(.ADDR_W(4), .DATA_W(8), .WR_CYCLES(4)) u_dut4 (
    .clk(clk), .clr_n(clr_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack4),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack4), .ldr_lock(ldr_lock),
    .rdata(rdata4), .bus_in(bus_in), .bus_drive(bus_drive4), .bus_out(bus_out4),
    .mar_load_n(mar_load_n4), .ram_oe_n(ram_oe_n4), .ram_we(ram_we4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    tick();
    tick();
    clr_n = 1'b1;
  endtask

  initial begin
    clr_n = 1'b0;
    {cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock} = '0;
    cpu_addr = '0; ldr_addr = '0; cpu_wdata = '0; ldr_wdata = '0; bus_in = '0;

    // Reset values
    tick();
    tick();
    check("rst_mar_load_n", 8'(mar_load_n), 8'h1);
    check("rst_ram_oe_n", 8'(ram_oe_n), 8'h1);
    check("rst_ram_we", 8'(ram_we), 8'h0);
    check("rst_bus_drive", 8'(bus_drive), 8'h0);
    check("rst_bus_out", bus_out, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_acks", 8'({cpu_ack, ldr_ack}), 8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    clr_n = 1'b1;
    tick();

    // CPU write 0xA5 to 0x3
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
    tick();
    check("wr_mar_strobe", 8'(mar_load_n), 8'h0);
    check("wr_mar_bus", bus_out, 8'h03);
    check("wr_mar_busy", 8'(busy), 8'h1);
    tick();
    check("wr_acc_mar_n", 8'(mar_load_n), 8'h1);
    check("wr_acc_we", 8'(ram_we), 8'h1);
    check("wr_acc_bus", bus_out, 8'hA5);
    check("wr_acc_drive", 8'(bus_drive), 8'h1);
    tick();
    check("wr_done_we", 8'(ram_we), 8'h0);
    check("wr_done_ack", 8'(cpu_ack), 8'h1);
    check("wr_done_drive", 8'(bus_drive), 8'h0);
    cpu_req = 1'b0;
    tick();
    check("wr_ack_width", 8'(cpu_ack), 8'h0);
    check("wr_idle_busy", 8'(busy), 8'h0);

    // CPU read of 0x3, bench returns 0xA5 during ACC
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h3;
    tick();
    check("rd_mar_bus", bus_out, 8'h03);
    tick();
    check("rd_acc_oe", 8'(ram_oe_n), 8'h0);
    check("rd_acc_drive", 8'(bus_drive), 8'h0);
    check("rd_acc_no_ack", 8'(cpu_ack), 8'h0);
    bus_in = 8'hA5;
    tick();
    bus_in = 8'h00;
    check("rd_done_oe", 8'(ram_oe_n), 8'h1);
    check("rd_done_drive", 8'(bus_drive), 8'h0);
    check("rd_rdata", rdata, 8'hA5);
    check("rd_ack", 8'(cpu_ack), 8'h1);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_width", 8'(cpu_ack), 8'h0);
    check("rd_rdata_hold", rdata, 8'hA5);

    // Both requesters held: round-robin starting with the CPU
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h1; cpu_wdata = 8'h11;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h2; ldr_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      logic exp_cpu;
      exp_cpu = (i % 2 == 0);
      tick();
      check("rr_mar_bus", bus_out, exp_cpu ? 8'h01 : 8'h02);
      tick();
      check("rr_acc_bus", bus_out, exp_cpu ? 8'h11 : 8'h22);
      tick();
      check("rr_cpu_ack", 8'(cpu_ack), 8'(exp_cpu));
      check("rr_ldr_ack", 8'(ldr_ack), 8'(!exp_cpu));
      tick();
      check("rr_idle_acks", 8'({cpu_ack, ldr_ack}), 8'h0);
      check("rr_idle_busy", 8'(busy), 8'h0);
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick();

    // Loader lock: only the loader is served until release
    ldr_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'h5;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 4'h6; ldr_wdata = 8'h66;
    tick();
    check("lk_mar_bus", bus_out, 8'h06);
    tick();
    check("lk_acc_bus", bus_out, 8'h66);
    tick();
    check("lk_ldr_ack", 8'(ldr_ack), 8'h1);
    check("lk_cpu_ack", 8'(cpu_ack), 8'h0);
    ldr_req = 1'b0;
    tick();
    tick();
    check("lk_blocked_busy", 8'(busy), 8'h0);
    check("lk_blocked_ack", 8'(cpu_ack), 8'h0);
    ldr_lock = 1'b0;
    tick();
    check("lk_cpu_mar_bus", bus_out, 8'h05);
    check("lk_cpu_mar_n", 8'(mar_load_n), 8'h0);
    tick();
    bus_in = 8'h5A;
    tick();
    bus_in = 8'h00;
    check("lk_cpu_ack_after", 8'(cpu_ack), 8'h1);
    check("lk_cpu_rdata", rdata, 8'h5A);
    cpu_req = 1'b0;
    tick();

    // WR_CYCLES=4 write aborted by reset during the 2nd write clock
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h9; cpu_wdata = 8'hC3;
    tick();
    tick();
    check("ab_we_1st", 8'(ram_we4), 8'h1);
    tick();
    check("ab_we_2nd", 8'(ram_we4), 8'h1);
    #2 clr_n = 1'b0;
    #1;
    check("ab_we_async", 8'(ram_we4), 8'h0);
    check("ab_drive_async", 8'(bus_drive4), 8'h0);
    check("ab_strobes_async", 8'({mar_load_n4, ram_oe_n4}), 8'h3);
    check("ab_busy_async", 8'(busy4), 8'h0);
    cpu_req = 1'b0;
    tick();
    check("ab_no_ack_rst", 8'(cpu_ack4), 8'h0);
    clr_n = 1'b1;
    tick();
    tick();
    check("ab_idle_busy", 8'(busy4), 8'h0);
    check("ab_no_ack_after", 8'(cpu_ack4), 8'h0);

    // Full WR_CYCLES=4 write: strobe 4 clocks, ack at clock 6
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h9; cpu_wdata = 8'hC3;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("w4_ram_we", 8'(ram_we4), 8'((k >= 2) && (k <= 5)));
      check("w4_ack", 8'(cpu_ack4), 8'(k == 6));
      if (k == 6) cpu_req = 1'b0;
    end
    tick();
    tick();

    // Request inputs changed and dropped right after the grant clock
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'hA; cpu_wdata = 8'h3C;
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 4'hF; cpu_wdata = 8'hFF;
    check("lt_mar_bus", bus_out, 8'h0A);
    tick();
    check("lt_acc_bus", bus_out, 8'h3C);
    check("lt_acc_we", 8'(ram_we), 8'h1);
    tick();
    check("lt_ack", 8'(cpu_ack), 8'h1);
    tick();
    check("lt_idle_busy", 8'(busy), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
